// File: rtl/mesi_types_pkg.sv
// Shared MESI bus types: snoop bus request encoding, arbiter FSM states and
// a width helper for index/counter registers.
package mesi_types;

    // Bus transaction requested by a cache controller; No_OP means idle.
    typedef enum logic [1:0] {
        No_OP   = 2'd0,
        BusRd   = 2'd1,
        BusRdX  = 2'd2,
        BusUpgr = 2'd3
    } bus_request;

    // Bus arbiter sequencing states.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned width_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mesi_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i,
// wrapping from NumReq-1 back to 0.
module mesi_rr_picker
    import mesi_types::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = width_min1(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              gnt_valid_o,
    output logic [IdxW-1:0]   gnt_idx_o
);

    // One extra bit so ptr + offset (at most 2*NumReq-2) never overflows before the wrap.
    logic [IdxW:0] sum;

    // Scan offsets 0..NumReq-1 from the pointer; first hit wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        sum         = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            sum = {1'b0, ptr_i} + (IdxW + 1)'(i);
            if (sum >= (IdxW + 1)'(NumReq)) begin
                sum = sum - (IdxW + 1)'(NumReq);
            end
            if (!gnt_valid_o && req_i[sum[IdxW-1:0]]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = sum[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared MESI snooping bus.
// One transaction at a time: grant, hold the broadcast for HOLD_CYCLES, then a
// one-cycle done pulse to the owner. All outputs are registered except
// exclusive_o, which reflects the live snoop line_valid_i.
// Optional feature macro: MESI_ARB_UPGR_PROMOTE_EN -- a pending BusUpgr whose
// Shared copy was invalidated by another owner's BusRdX/BusUpgr to the same
// address is broadcast as BusRdX when granted.
module mesi_bus_arbiter
    import mesi_types::*;
#(
    parameter int unsigned NUM_CACHES  = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  bus_request [NUM_CACHES-1:0]        req_cmd_i,
    input  logic [NUM_CACHES-1:0][ADDR_W-1:0]  req_addr_i,
    input  logic [NUM_CACHES-1:0]              line_valid_i,
    output bus_request                         bus_cmd_o,
    output logic [ADDR_W-1:0]                  bus_addr_o,
    output logic [NUM_CACHES-1:0]              bus_owner_o,
    output logic                               exclusive_o,
    output logic [NUM_CACHES-1:0]              done_o,
    output logic                               busy_o
);

    localparam int unsigned IdxW  = width_min1(NUM_CACHES);
    localparam int unsigned HoldW = width_min1(HOLD_CYCLES);

    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_CACHES - 1);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES - 1);

    arb_state_t             state_q, state_d;
    bus_request             cmd_q, cmd_d;        // latched (possibly promoted) command
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic [IdxW-1:0]        rr_q, rr_d;
    bus_request             bus_cmd_q, bus_cmd_d;
    logic [NUM_CACHES-1:0]  owner_q, owner_d;
    logic [NUM_CACHES-1:0]  done_q, done_d;
    logic                   busy_q, busy_d;

    logic [NUM_CACHES-1:0]  req_vld;
    logic                   gnt_valid;
    logic [IdxW-1:0]        win_idx;
    bus_request             win_cmd;

    // Any non-idle command counts as a pending request.
    always_comb begin
        req_vld = '0;
        for (int unsigned j = 0; j < NUM_CACHES; j++) begin
            req_vld[j] = (req_cmd_i[IdxW'(j)] != No_OP);
        end
    end

    mesi_rr_picker #(
        .NumReq (NUM_CACHES),
        .IdxW   (IdxW)
    ) u_picker (
        .req_i       (req_vld),
        .ptr_i       (rr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (win_idx)
    );

`ifdef MESI_ARB_UPGR_PROMOTE_EN
    logic [NUM_CACHES-1:0] mark_q, mark_d;

    // At the end of an invalidating transaction, flag other caches still waiting to
    // upgrade the same line; the owner's own flag clears on its done.
    always_comb begin
        mark_d = mark_q;
        if (state_q == ARB_DONE) begin
            mark_d[idx_q] = 1'b0;
            if (cmd_q == BusRdX || cmd_q == BusUpgr) begin
                for (int unsigned j = 0; j < NUM_CACHES; j++) begin
                    if (IdxW'(j) != idx_q && req_cmd_i[IdxW'(j)] == BusUpgr &&
                        req_addr_i[IdxW'(j)] == addr_q) begin
                        mark_d[j] = 1'b1;
                    end
                end
            end
        end
    end

    // Upgrade marks register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mark_q <= '0;
        end else begin
            mark_q <= mark_d;
        end
    end

    // A marked upgrade no longer has a Shared copy, so it must fetch the line.
    always_comb begin
        win_cmd = req_cmd_i[win_idx];
        if (mark_q[win_idx] && req_cmd_i[win_idx] == BusUpgr) begin
            win_cmd = BusRdX;
        end
    end
`else
    // Requests are broadcast exactly as presented.
    always_comb begin
        win_cmd = req_cmd_i[win_idx];
    end
`endif

    // FSM next state: grant in idle, hold the bus, then one done cycle.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_d = ARB_BUS;
                    cmd_d   = win_cmd;
                    addr_d  = req_addr_i[win_idx];
                    idx_d   = win_idx;
                    hold_d  = HoldInit;
                end
            end
            ARB_BUS: begin
                if (hold_q == '0) begin
                    state_d = ARB_DONE;
                end else begin
                    hold_d = hold_q - HoldW'(1);
                end
            end
            ARB_DONE: begin
                rr_d    = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with it.
    always_comb begin
        bus_cmd_d = No_OP;
        owner_d   = '0;
        done_d    = '0;
        busy_d    = (state_d != ARB_IDLE);
        if (state_d == ARB_BUS) begin
            bus_cmd_d      = cmd_d;
            owner_d[idx_d] = 1'b1;
        end
        if (state_d == ARB_DONE) begin
            done_d[idx_d] = 1'b1;
        end
    end

    // State and output registers; reset aborts any transaction without a done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            cmd_q     <= No_OP;
            addr_q    <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            rr_q      <= '0;
            bus_cmd_q <= No_OP;
            owner_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            rr_q      <= rr_d;
            bus_cmd_q <= bus_cmd_d;
            owner_q   <= owner_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_cmd_o   = bus_cmd_q;
    assign bus_addr_o  = addr_q;
    assign bus_owner_o = owner_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

    // A BusRd may fill Exclusive only if no other cache holds the line.
    assign exclusive_o = (state_q == ARB_BUS) && (bus_cmd_q == BusRd) &&
                         !(|(line_valid_i & ~owner_q));

endmodule
